alu_seq_muldiv: RTL and testbench
=================================

Name: alu_seq_muldiv

Overview:
- Parametrised, handshaked successor of the single-cycle pipeline ALU.
- Adds unsigned compare, shifts, and iterative multiply/divide with a HI/LO result pair.
- Sits in the EX stage; the hazard unit stalls the pipeline while busy=1.
- Simple ops finish in 1 cycle; MUL/DIV use a shift-add / restoring-divide FSM.

Parameters:
- WIDTH, 32, operand/result width (≥8, power of 2).
- SHW, $clog2(WIDTH), shift-amount width, derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only on an edge where busy=0.
- aluoperation  in  4  op code, sampled with start.
- data1  in  WIDTH  operand A, sampled with start.
- data2  in  WIDTH  operand B, sampled with start.
- result  out  WIDTH  LO result (quotient for divide).
- result_hi  out  WIDTH  HI result (product upper half / remainder); 0 for simple ops.
- zero  out  1  result==0.
- lt  out  1  signed data1<data2.
- gt  out  1  signed data1>data2.
- ltu  out  1  unsigned data1<data2.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse; outputs valid and held from this cycle on.

Behaviour:
- Reset, synchronous and active-high, sets every output to 0 and the FSM to IDLE.
- Reset mid-operation aborts; no done pulse for the aborted op.
- Op codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT (signed), 0110 SLTU.
  - 0111 SLL, 1100 SRL, 1101 SRA; shift amount = data2[SHW-1:0].
  - 1000 MULU, 1001 MUL (signed): {result_hi,result} = 2*WIDTH product.
  - 1010 DIVU, 1011 DIV (signed, truncating): quotient in result, remainder in result_hi; remainder takes the dividend's sign.
  - 1110, 1111: behave as ADD.
- Arithmetic is mod 2^WIDTH; no overflow flag.
- Flags: lt/gt/ltu come from the sampled operands; zero comes from the final result. All flags register together with result.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE + start + simple op → DONE; done asserted 1 edge after the accepting edge.
  - IDLE + start + mul/div → CALC. Signed ops latch operand magnitudes and the sign of the result and of the remainder.
  - CALC lasts exactly WIDTH cycles, one bit per cycle. A counter runs WIDTH-1 down to 0, then → FIX.
  - FIX applies sign correction and loads outputs → DONE. done asserted WIDTH+2 edges after the accepting edge.
  - DONE: done=1, busy=0 for one cycle → IDLE. A start in the DONE cycle is accepted (back-to-back).
- busy is 1 in CALC and FIX and 0 otherwise. A simple op never raises busy.
- start while busy=1 is ignored; operands are not resampled.
- Divide by zero: result=all ones, result_hi=dividend, full latency.
- Signed DIV with MIN / -1: result=MIN, result_hi=0.
- Outputs hold their values until the next done; they never change mid-operation.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: MUL/DIV hardware and the CALC/FIX states are present, as above.
- Undefined: no multiplier/divider or counter is built. Op codes 1000-1011 behave as ADD with 1-cycle latency; result_hi=0 and busy stays 0.

Test Plan:
- Reset, then ADD 0x7FFFFFFF+1 → done at edge 1; result=0x80000000, zero=0, gt=1, lt=0, ltu=0.
- SLT with data1=0xFFFFFFFF, data2=1 → result=1, lt=1, gt=0, ltu=0; SLTU on the same operands → result=0, ltu=0. SRA 0x80000000 by 4 → 0xF8000000.
- MUL -3 × 7 → busy for 33 cycles, done at edge 34; result=0xFFFFFFEB, result_hi=0xFFFFFFFF. MULU 0xFFFFFFFF² → result=1, result_hi=0xFFFFFFFE.
- DIV -7/2 → result=0xFFFFFFFD, result_hi=0xFFFFFFFF. DIVU 100/7 → result=14, result_hi=2. DIV 5/0 → result=0xFFFFFFFF, result_hi=5. DIV 0x80000000/-1 → result=0x80000000, result_hi=0.
- Start ADD while a MUL is busy → ignored and MUL result unchanged; start issued in the DONE cycle is accepted and completes.
- Assert rst at cycle 10 of a DIVU → all outputs 0 on the next edge, no done pulse; a new ADD then completes normally.

Source files
------------

// File: rtl/alu_seq_muldiv.sv
// Handshaked EX-stage ALU: simple ops finish in one cycle, iterative MUL/DIV in WIDTH+2 cycles.
// Build option: define ALU_MULDIV_EN to include the shift-add multiplier / restoring divider.
module alu_seq_muldiv #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       aluoperation,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             lt,
    output logic             gt,
    output logic             ltu,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic             zero_q, zero_d, lt_q, lt_d, gt_q, gt_d, ltu_q, ltu_d;
    logic             accept, is_md, flag_lt, flag_gt, flag_ltu;
    logic [WIDTH-1:0] simple_res;
    logic [SHW-1:0]   shamt;

    // DONE is a free slot, so a new request may be taken there back-to-back
    assign accept   = start && (state_q == IDLE || state_q == DONE);
    assign flag_lt  = $signed(data1) < $signed(data2);
    assign flag_gt  = $signed(data1) > $signed(data2);
    assign flag_ltu = data1 < data2;
    assign shamt    = data2[SHW-1:0];

    always_comb begin
        case (aluoperation)
            4'b0001: simple_res = data1 - data2;
            4'b0010: simple_res = data1 & data2;
            4'b0011: simple_res = data1 | data2;
            4'b0100: simple_res = data1 ^ data2;
            4'b0101: simple_res = {{(WIDTH-1){1'b0}}, flag_lt};
            4'b0110: simple_res = {{(WIDTH-1){1'b0}}, flag_ltu};
            4'b0111: simple_res = data1 << shamt;
            4'b1100: simple_res = data1 >> shamt;
            4'b1101: simple_res = $unsigned($signed(data1) >>> shamt);
            default: simple_res = data1 + data2;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic               is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, div0_q, div0_d;
    logic [2:0]         flg_q, flg_d;
    logic               a_neg, b_neg, div_ge;
    logic [WIDTH-1:0]   a_mag, b_mag, div_diff, quo, rem, fix_lo;
    logic [WIDTH:0]     mul_sum, div_r;
    logic [2*WIDTH-1:0] prod;

    assign is_md    = aluoperation[3:2] == 2'b10;
    assign a_neg    = aluoperation[0] & data1[WIDTH-1];
    assign b_neg    = aluoperation[0] & data2[WIDTH-1];
    assign a_mag    = a_neg ? -data1 : data1;
    assign b_mag    = b_neg ? -data2 : data2;
    // hi/lo act as {partial product, multiplier} or {remainder, dividend/quotient}
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_r    = {hi_q, lo_q[WIDTH-1]};
    assign div_ge   = div_r >= {1'b0, b_q};
    assign div_diff = div_r[WIDTH-1:0] - b_q;
    assign prod     = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    // divide by zero naturally leaves |dividend| as remainder; only the quotient needs forcing
    assign quo      = div0_q ? '1 : (neg_q ? -lo_q : lo_q);
    assign rem      = rneg_q ? -hi_q : hi_q;
    assign fix_lo   = is_div_q ? quo : prod[WIDTH-1:0];
`else
    assign is_md = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        lt_d        = lt_q;
        gt_d        = gt_q;
        ltu_d       = ltu_q;
`ifdef ALU_MULDIV_EN
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        flg_d    = flg_q;
`endif
        case (state_q)
`ifdef ALU_MULDIV_EN
            CALC: begin
                if (is_div_q) begin
                    hi_d = div_ge ? div_diff : div_r[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_ge};
                end else begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                state_d     = DONE;
                result_d    = fix_lo;
                result_hi_d = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
                zero_d      = fix_lo == '0;
                {lt_d, gt_d, ltu_d} = flg_q;
            end
`endif
            DONE:    state_d = IDLE;
            default: ;
        endcase
        if (accept) begin
            if (is_md) begin
`ifdef ALU_MULDIV_EN
                state_d  = CALC;
                cnt_d    = SHW'(WIDTH - 1);
                hi_d     = '0;
                lo_d     = a_mag;
                b_d      = b_mag;
                is_div_d = aluoperation[1];
                neg_d    = a_neg ^ b_neg;
                rneg_d   = a_neg;
                div0_d   = data2 == '0;
                flg_d    = {flag_lt, flag_gt, flag_ltu};
`endif
            end else begin
                state_d     = DONE;
                result_d    = simple_res;
                result_hi_d = '0;
                zero_d      = simple_res == '0;
                lt_d        = flag_lt;
                gt_d        = flag_gt;
                ltu_d       = flag_ltu;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            lt_q        <= 1'b0;
            gt_q        <= 1'b0;
            ltu_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            lt_q        <= lt_d;
            gt_q        <= gt_d;
            ltu_q       <= ltu_d;
        end
    end

`ifdef ALU_MULDIV_EN
    always_ff @(posedge clk) begin
        cnt_q    <= cnt_d;
        hi_q     <= hi_d;
        lo_q     <= lo_d;
        b_q      <= b_d;
        is_div_q <= is_div_d;
        neg_q    <= neg_d;
        rneg_q   <= rneg_d;
        div0_q   <= div0_d;
        flg_q    <= flg_d;
    end
`endif

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign lt        = lt_q;
    assign gt        = gt_q;
    assign ltu       = ltu_q;
    assign busy      = state_q == CALC || state_q == FIX;
    assign done      = state_q == DONE;
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Table-driven bench for alu_seq_muldiv plus directed multi-cycle sequences.
module tb_alu_seq_muldiv;
    localparam int W = 32;
`ifdef ALU_MULDIV_EN
    localparam int MDL = W + 2;
`else
    localparam int MDL = 1;
`endif

    logic         clk = 1'b0;
    logic         rst, start;
    logic [3:0]   op;
    logic [W-1:0] d1, d2, result, result_hi;
    logic         zero, lt, gt, ltu, busy, done;
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    alu_seq_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .aluoperation(op),
        .data1(d1), .data2(d2), .result(result), .result_hi(result_hi),
        .zero(zero), .lt(lt), .gt(gt), .ltu(ltu), .busy(busy), .done(done)
    );

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a, b, res, hi;
        logic [3:0]   flg;  // {zero, lt, gt, ltu}
        int           lat;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input string n, input logic [3:0] o, input logic [W-1:0] a, b,
                           input logic [W-1:0] r, h, input logic [3:0] f, input int l);
        vec_t v;
        v.name = n; v.op = o; v.a = a; v.b = b; v.res = r; v.hi = h; v.flg = f; v.lat = l;
        vecs.push_back(v);
    endtask

    task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Drive one request; lat counts edges from the accepting edge to the edge sampling done.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, b,
                          output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; op = o; d1 = a; d2 = b;
        @(posedge clk);
        lat = 1; bcnt = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat, bcnt, n, dcnt;
        rst = 1'b1; start = 1'b0; op = '0; d1 = '0; d2 = '0;

        add_vec("add",   4'b0000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 32'h0, 4'b0010, 1);
        add_vec("slt",   4'b0101, 32'hFFFFFFFF, 32'h1,        32'h1,        32'h0, 4'b0100, 1);
        add_vec("sltu",  4'b0110, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0, 4'b1100, 1);
        add_vec("sra",   4'b1101, 32'h80000000, 32'h4,        32'hF8000000, 32'h0, 4'b0100, 1);
        add_vec("sub",   4'b0001, 32'h5,        32'h5,        32'h0,        32'h0, 4'b1000, 1);
        add_vec("and",   4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 4'b0101, 1);
        add_vec("or",    4'b0011, 32'h0F,       32'hF0,       32'hFF,       32'h0, 4'b0101, 1);
        add_vec("xor",   4'b0100, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 32'h0, 4'b0101, 1);
        add_vec("sll",   4'b0111, 32'h1,        32'd31,       32'h80000000, 32'h0, 4'b0101, 1);
        add_vec("srl",   4'b1100, 32'h80000000, 32'd35,       32'h10000000, 32'h0, 4'b0100, 1);
        add_vec("op14",  4'b1110, 32'h3,        32'h4,        32'h7,        32'h0, 4'b0101, 1);
        add_vec("op15",  4'b1111, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0, 4'b1100, 1);
`ifdef ALU_MULDIV_EN
        add_vec("mul",   4'b1001, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFEB, 32'hFFFFFFFF, 4'b0100, MDL);
        add_vec("mulu",  4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFE, 4'b0000, MDL);
        add_vec("div",   4'b1011, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF, 4'b0100, MDL);
        add_vec("divu",  4'b1010, 32'd100,      32'd7,        32'd14,       32'd2,        4'b0010, MDL);
        add_vec("div0",  4'b1011, 32'd5,        32'h0,        32'hFFFFFFFF, 32'd5,        4'b0010, MDL);
        add_vec("divmn", 4'b1011, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        4'b0101, MDL);
        add_vec("mulz",  4'b1000, 32'h10000,    32'h10000,    32'h0,        32'h1,        4'b1000, MDL);
`else
        add_vec("mul",   4'b1001, 32'hFFFFFFFD, 32'h7,        32'h4,        32'h0, 4'b0100, MDL);
        add_vec("mulu",  4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 4'b0000, MDL);
        add_vec("div",   4'b1011, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFB, 32'h0, 4'b0100, MDL);
        add_vec("divu",  4'b1010, 32'd100,      32'd7,        32'd107,      32'h0, 4'b0010, MDL);
        add_vec("div0",  4'b1011, 32'd5,        32'h0,        32'd5,        32'h0, 4'b0010, MDL);
        add_vec("divmn", 4'b1011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0, 4'b0101, MDL);
        add_vec("mulz",  4'b1000, 32'h10000,    32'h10000,    32'h20000,    32'h0, 4'b0000, MDL);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset result", result, '0);
        chk("reset result_hi", result_hi, '0);
        chk("reset flags", W'({zero, lt, gt, ltu, busy, done}), '0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            chk({vecs[i].name, " result"}, result, vecs[i].res);
            chk({vecs[i].name, " result_hi"}, result_hi, vecs[i].hi);
            chk({vecs[i].name, " flags"}, W'({zero, lt, gt, ltu}), W'(vecs[i].flg));
            chk({vecs[i].name, " latency"}, W'(lat), W'(vecs[i].lat));
            chk({vecs[i].name, " busy cycles"}, W'(bcnt), W'((vecs[i].lat > 1) ? W + 1 : 0));
        end

`ifdef ALU_MULDIV_EN
        // start while busy must be ignored
        @(negedge clk);
        start = 1'b1; op = 4'b1001; d1 = 32'hFFFFFFFD; d2 = 32'h7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 4'b0000; d1 = 32'h1; d2 = 32'h1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("ignore done seen", W'(done), W'(1));
        chk("ignore result", result, 32'hFFFFFFEB);
        chk("ignore result_hi", result_hi, 32'hFFFFFFFF);
        @(negedge clk);
        chk("ignore no extra done", W'({done, busy}), '0);
        chk("ignore result held", result, 32'hFFFFFFEB);
`endif

        // back-to-back: new request issued in the DONE cycle
        @(negedge clk);
        start = 1'b1; op = 4'b1000; d1 = 32'd6; d2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("b2b first result", result, (MDL > 1) ? 32'd42 : 32'd13);
        start = 1'b1; op = 4'b0001; d1 = 32'd10; d2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("b2b second done", W'(done), W'(1));
        chk("b2b second result", result, 32'd7);
        chk("b2b second result_hi", result_hi, '0);

        // reset during a DIVU aborts it silently
        @(negedge clk);
        start = 1'b1; op = 4'b1010; d1 = 32'd100; d2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort outputs", result | result_hi, '0);
        chk("abort flags", W'({zero, lt, gt, ltu, busy, done}), '0);
        rst = 1'b0;
        dcnt = 0;
        repeat (40) begin @(negedge clk); if (done) dcnt++; end
        chk("abort no done", W'(dcnt), '0);
        run_op(4'b0000, 32'd20, 32'd22, lat, bcnt);
        chk("post-abort result", result, 32'd42);
        chk("post-abort latency", W'(lat), W'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
